// File: rtl/filter_pkg.sv
// Shared definitions for the average_filter / decim_buffer sample path.
// Default widths, the sample type and a constant-safe clog2.
package filter_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 4;

    typedef logic [DATA_WIDTH-1:0] sample_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO with wrap-bit pointers.
// The head value is held after the last pop so the output never glitches to stale slots.
module sync_fifo
    import filter_pkg::*;
#(
    parameter int  DATA_WIDTH = filter_pkg::DATA_WIDTH,
    parameter int  FIFO_DEPTH = filter_pkg::FIFO_DEPTH,
    localparam int AW         = clog2(FIFO_DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [LW-1:0]         level
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] hold_q;
    logic [LW-1:0]         wr_ptr;
    logic [LW-1:0]         rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    assign rd_en = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign rdata = empty ? hold_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/decim_buffer.sv
// Keeps every R-th filter sample and buffers it for a valid/ready consumer.
// Phase counter, keep/drop decision and sticky overflow live here; storage is in sync_fifo.
module decim_buffer
    import filter_pkg::*;
#(
    parameter int  DATA_WIDTH  = filter_pkg::DATA_WIDTH,
    parameter int  FIFO_DEPTH  = filter_pkg::FIFO_DEPTH,
    parameter int  DECIM_WIDTH = 4,
    localparam int LW          = clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_ce,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [DECIM_WIDTH-1:0] i_decim,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [LW-1:0]          o_level,
    output logic                   o_overflow,
    input  logic                   i_clear_ovf,
    output logic [DECIM_WIDTH-1:0] o_phase,
    output logic                   o_keep
);

    logic [DECIM_WIDTH-1:0] phase_q;
    logic [DECIM_WIDTH-1:0] last_phase;
    logic                   keep;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   ovf_q;

    // Factor 0 behaves as 1, so the last legal phase is 0 in that case.
    assign last_phase = (i_decim == '0) ? '0 : i_decim - 1'b1;
    assign keep       = i_ce && (phase_q == '0);
    assign pop        = o_valid && i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else if (i_ce) begin
            // >= lets a shrinking factor wrap without visiting an illegal phase.
            if (phase_q >= last_phase) phase_q <= '0;
            else                       phase_q <= phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (keep && full && !pop) begin
            ovf_q <= 1'b1;
        end else if (i_clear_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (keep),
        .pop     (pop),
        .wdata   (data_in),
        .rdata   (data_out),
        .full    (full),
        .empty   (empty),
        .level   (o_level)
    );

    assign o_valid    = !empty;
    assign o_overflow = ovf_q;
    assign o_phase    = phase_q;
    assign o_keep     = keep;

endmodule

// File: tb/tb_decim_buffer.sv
// Directed bench for decim_buffer with a queue-based reference model.
module tb_decim_buffer;
    import filter_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       i_ce = 1'b0;
    sample_t    data_in = '0;
    logic [3:0] i_decim = 4'd1;
    logic       i_ready = 1'b0;
    logic       i_clear_ovf = 1'b0;
    logic       o_valid;
    sample_t    data_out;
    logic [2:0] o_level;
    logic       o_overflow;
    logic [3:0] o_phase;
    logic       o_keep;

    decim_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_ce        (i_ce),
        .data_in     (data_in),
        .i_decim     (i_decim),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .data_out    (data_out),
        .o_level     (o_level),
        .o_overflow  (o_overflow),
        .i_clear_ovf (i_clear_ovf),
        .o_phase     (o_phase),
        .o_keep      (o_keep)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of kept samples, a phase count and a sticky flag.
    sample_t mq[$];
    int      m_phase = 0;
    bit      m_ovf = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_phase = 0;
            m_ovf   = 1'b0;
        end else begin
            int  reff;
            bit  kp;
            bit  pp;
            int  sz;
            reff = (i_decim == 0) ? 1 : int'(i_decim);
            kp   = i_ce && (m_phase == 0);
            sz   = mq.size();
            pp   = (sz != 0) && i_ready;
            if (pp) void'(mq.pop_front());
            if (kp) begin
                if (sz < DEPTH || pp) mq.push_back(data_in);
            end
            if (kp && sz == DEPTH && !pp) m_ovf = 1'b1;
            else if (i_clear_ovf)         m_ovf = 1'b0;
            if (i_ce) m_phase = (m_phase >= reff - 1) ? 0 : m_phase + 1;
        end
    end

    sample_t got[$];
    sample_t expq[$];
    int      max_lvl = 0;

    always @(negedge clk) begin
        check("valid", o_valid, mq.size() != 0);
        check("level", o_level, mq.size());
        check("overflow", o_overflow, m_ovf);
        check("keep", o_keep, i_ce && m_phase == 0);
        check("phase", o_phase, m_phase);
        if (mq.size() != 0) check("data_out", data_out, mq[0]);
        if (o_valid && i_ready) got.push_back(data_out);
        if (int'(o_level) > max_lvl) max_lvl = o_level;
    end

    task automatic drive(input bit ce, input sample_t d, input bit rdy);
        @(posedge clk);
        #1;
        i_ce    = ce;
        data_in = d;
        i_ready = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        i_ce = 1'b0;
        i_ready = 1'b0;
        i_clear_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_seq(input string nm);
        check({nm, "_len"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < got.size()) check(nm, got[i], expq[i]);
        end
    endtask

    task automatic run_s1();
        got.delete();
        max_lvl = 0;
        drive(1, 8'h10, 1);
        drive(0, 8'h00, 1);
        drive(1, 8'h20, 1);
        drive(0, 8'h00, 1);
        drive(1, 8'h30, 1);
        repeat (4) drive(0, 8'h00, 1);
        @(negedge clk);
        expq = '{8'h10, 8'h20, 8'h30};
        check_seq("s1_order");
        check("s1_max_level", max_lvl, 1);
        check("s1_ovf", o_overflow, 0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #20 reset_n = 1'b1;
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_level", o_level, 0);
        check("rst_data", data_out, 0);

        // R=1, spaced samples
        i_decim = 4'd1;
        run_s1();

        // R=3 keeps 1st, 4th, 7th
        do_reset();
        i_decim = 4'd3;
        got.delete();
        for (int i = 1; i <= 9; i++) drive(1, sample_t'(i), 1);
        repeat (3) drive(0, 8'h00, 1);
        @(negedge clk);
        expq = '{8'h01, 8'h04, 8'h07};
        check_seq("s2_order");

        // Overflow with stalled consumer
        do_reset();
        i_decim = 4'd1;
        for (int i = 0; i < 5; i++) drive(1, sample_t'(8'hA0 + i), 0);
        drive(0, 8'h00, 0);
        @(negedge clk);
        check("s3_level", o_level, 4);
        check("s3_valid", o_valid, 1);
        check("s3_head", data_out, 8'hA0);
        check("s3_ovf", o_overflow, 1);
        got.delete();
        repeat (6) drive(0, 8'h00, 1);
        @(negedge clk);
        expq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        check_seq("s3_order");
        check("s3_ovf_sticky", o_overflow, 1);
        @(posedge clk);
        #1 i_clear_ovf = 1'b1;
        @(posedge clk);
        #1 i_clear_ovf = 1'b0;
        @(negedge clk);
        check("s3_ovf_clr", o_overflow, 0);

        // Full plus simultaneous push and pop
        for (int i = 0; i < 4; i++) drive(1, sample_t'(8'hB0 + i), 0);
        got.delete();
        drive(1, 8'hB4, 1);
        drive(0, 8'h00, 1);
        @(negedge clk);
        check("s4_level", o_level, 4);
        check("s4_ovf", o_overflow, 0);
        repeat (5) drive(0, 8'h00, 1);
        @(negedge clk);
        expq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        check_seq("s4_order");

        // Reset mid-operation with phase=2 and two entries
        do_reset();
        i_decim = 4'd4;
        for (int i = 0; i < 6; i++) drive(1, sample_t'(8'h50 + i), 0);
        drive(0, 8'h00, 0);
        @(negedge clk);
        check("s5_pre_level", o_level, 2);
        check("s5_pre_phase", o_phase, 2);
        @(posedge clk);
        #3 reset_n = 1'b0;
        @(negedge clk);
        check("s5_rst_valid", o_valid, 0);
        check("s5_rst_level", o_level, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        got.delete();
        drive(1, 8'hC0, 1);
        drive(0, 8'h00, 1);
        @(negedge clk);
        check("s5_first_valid", o_valid, 1);
        check("s5_first_data", data_out, 8'hC0);
        repeat (2) drive(0, 8'h00, 1);
        @(negedge clk);
        expq = '{8'hC0};
        check_seq("s5_order");

        // Factor 0 behaves as 1
        do_reset();
        i_decim = 4'd0;
        run_s1();

        // Factor change 5 -> 2 at phase 4
        do_reset();
        i_decim = 4'd5;
        got.delete();
        for (int i = 0; i < 4; i++) drive(1, sample_t'(8'hD0 + i), 1);
        drive(0, 8'h00, 1);
        @(negedge clk);
        check("s6_phase4", o_phase, 4);
        @(posedge clk);
        #1;
        i_decim = 4'd2;
        i_ce = 1'b1;
        data_in = 8'hD4;
        for (int i = 5; i < 9; i++) drive(1, sample_t'(8'hD0 + i), 1);
        repeat (3) drive(0, 8'h00, 1);
        @(negedge clk);
        expq = '{8'hD0, 8'hD5, 8'hD7};
        check_seq("s6_order");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
